// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipe_stage_reg slice.
// Holds the default field widths for the MEM->WB boundary, the bit positions
// of the control bits, the stage state encoding and a helper that turns a
// state into the number of held entries.
package pipe_stage_reg_pkg;

  localparam int CTRL_W_DEF = 2;
  localparam int DATA_W_DEF = 32;
  localparam int RD_W_DEF   = 5;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;

  // EMPTY = (main,skid) = (0,0), FULL = (1,0), SKID = (1,1)
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

  function automatic logic [1:0] occupancy(input stage_state_e s);
    case (s)
      ST_FULL: occupancy = 2'd1;
      ST_SKID: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake and datapath bundle of one pipeline stage register.
// Upstream side : in_valid_i, in_ready_o, in_ctrl_i, in_alu_i, in_mem_i, in_rd_i
// Downstream    : out_valid_o, out_ready_i, out_ctrl_o, out_alu_o, out_mem_o,
//                 out_rd_o
// Control       : flush_i (synchronous kill), occ_o (entries held)
// The slave modport is taken by the stage itself, master by whoever drives it.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = pipe_stage_reg_pkg::CTRL_W_DEF,
  parameter int DATA_W = pipe_stage_reg_pkg::DATA_W_DEF,
  parameter int RD_W   = pipe_stage_reg_pkg::RD_W_DEF
);
  import pipe_stage_reg_pkg::*;

  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [CTRL_W-1:0] in_ctrl_i;
  logic [DATA_W-1:0] in_alu_i;
  logic [DATA_W-1:0] in_mem_i;
  logic [RD_W-1:0]   in_rd_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic [DATA_W-1:0] out_alu_o;
  logic [DATA_W-1:0] out_mem_o;
  logic [RD_W-1:0]   out_rd_o;
  logic [1:0]        occ_o;

  modport slave (
    input  flush_i, in_valid_i, in_ctrl_i, in_alu_i, in_mem_i, in_rd_i,
           out_ready_i,
    output in_ready_o, out_valid_o, out_ctrl_o, out_alu_o, out_mem_o,
           out_rd_o, occ_o
  );

  modport master (
    output flush_i, in_valid_i, in_ctrl_i, in_alu_i, in_mem_i, in_rd_i,
           out_ready_i,
    input  in_ready_o, out_valid_o, out_ctrl_o, out_alu_o, out_mem_o,
           out_rd_o, occ_o
  );

endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One storage entry of the stage: valid flag plus ctrl/alu/mem/rd fields.
// Ports: clk, rst (async, active-high), load (capture d_* and set valid),
//        clear (drop valid and zero ctrl; data fields keep stale values),
//        d_* incoming fields, valid/ctrl/alu/mem/rd stored entry.
module pipe_stage_reg_slot #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_alu,
  input  logic [DATA_W-1:0] d_mem,
  input  logic [RD_W-1:0]   d_rd,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] alu,
  output logic [DATA_W-1:0] mem,
  output logic [RD_W-1:0]   rd
);
  import pipe_stage_reg_pkg::*;

  // Clear beats load so a flush can never leave a live entry behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      alu   <= '0;
      mem   <= '0;
      rd    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      alu   <= d_alu;
      mem   <= d_mem;
      rd    <= d_rd;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// MEM/WB-class pipeline stage register with valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush and bubble-safe control outputs.
// Ports: clk, rst (async, active-high), bus (slave side of pipe_stage_reg_if).
// SKID=1 gives a registered in_ready_o (a pure function of the state register);
// SKID=0 keeps a single entry and lets out_ready_i pass straight to in_ready_o.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF,
  parameter int SKID   = 1
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_reg_if.slave bus
);

  stage_state_e state, next_state;

  logic in_fire, out_fire;
  logic main_load, main_clear, main_from_skid;
  logic skid_load, skid_clear;

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_alu, main_mem;
  logic [RD_W-1:0]   main_rd;

  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_alu, skid_mem;
  logic [RD_W-1:0]   skid_rd;

  assign in_fire  = bus.in_valid_i & bus.in_ready_o;
  assign out_fire = bus.out_valid_o & bus.out_ready_i;

  // State register; async reset drops any in-flight entries at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= next_state;
  end

  // Next state and slot controls. Flush overrides both handshakes, so a
  // fire in the flush cycle never reaches the slots.
  always_comb begin
    next_state     = state;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (bus.flush_i) begin
      next_state = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_load  = 1'b1;
            next_state = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire && SKID != 0) begin
            skid_load  = 1'b1;
            next_state = ST_SKID;
          end else if (in_fire) begin
            main_load = 1'b1;
          end else if (out_fire) begin
            main_clear = 1'b1;
            next_state = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            next_state     = ST_FULL;
          end
        end
        default: next_state = ST_EMPTY;
      endcase
    end
  end

  pipe_stage_reg_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .RD_W(RD_W)) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (main_load),
    .clear  (main_clear),
    .d_ctrl (main_from_skid ? skid_ctrl : bus.in_ctrl_i),
    .d_alu  (main_from_skid ? skid_alu  : bus.in_alu_i),
    .d_mem  (main_from_skid ? skid_mem  : bus.in_mem_i),
    .d_rd   (main_from_skid ? skid_rd   : bus.in_rd_i),
    .valid  (main_valid),
    .ctrl   (main_ctrl),
    .alu    (main_alu),
    .mem    (main_mem),
    .rd     (main_rd)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_stage_reg_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .RD_W(RD_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .clear  (skid_clear),
        .d_ctrl (bus.in_ctrl_i),
        .d_alu  (bus.in_alu_i),
        .d_mem  (bus.in_mem_i),
        .d_rd   (bus.in_rd_i),
        .valid  (skid_valid),
        .ctrl   (skid_ctrl),
        .alu    (skid_alu),
        .mem    (skid_mem),
        .rd     (skid_rd)
      );
    end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_alu   = '0;
      assign skid_mem   = '0;
      assign skid_rd    = '0;
    end
  endgenerate

  // With a skid buffer the stall signal depends only on the state register;
  // without one, a full stage can still accept when the head leaves.
  assign bus.in_ready_o = (SKID != 0) ? (state != ST_SKID)
                                      : ((state == ST_EMPTY) | bus.out_ready_i);

  assign bus.out_valid_o = (state != ST_EMPTY);
  assign bus.out_ctrl_o  = bus.out_valid_o ? main_ctrl : '0;
  assign bus.out_alu_o   = main_alu;
  assign bus.out_mem_o   = main_mem;
  assign bus.out_rd_o    = main_rd;
  assign bus.occ_o       = occupancy(state);

  // Slot valid flags must track the state encoding; skid without main is
  // never legal.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(skid_valid && !main_valid));
      assert (main_valid == (state != ST_EMPTY));
      assert (skid_valid == (state == ST_SKID));
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg.
// dut_a is the skid-buffered build, dut_b the single-entry build; both share
// clock and reset. Inputs change 1 ns after a rising edge and outputs are
// sampled 1 ns after the following rising edge.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  pipe_stage_reg_if bus_a ();
  pipe_stage_reg_if bus_b ();

  pipe_stage_reg #(.SKID(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  pipe_stage_reg #(.SKID(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input bit sel_b, input logic valid,
                               input logic [1:0] ctrl, input logic [31:0] alu,
                               input logic [31:0] mem, input logic [4:0] rd,
                               input logic out_ready, input logic flush);
    if (sel_b) begin
      bus_b.in_valid_i  = valid;
      bus_b.in_ctrl_i   = ctrl;
      bus_b.in_alu_i    = alu;
      bus_b.in_mem_i    = mem;
      bus_b.in_rd_i     = rd;
      bus_b.out_ready_i = out_ready;
      bus_b.flush_i     = flush;
    end else begin
      bus_a.in_valid_i  = valid;
      bus_a.in_ctrl_i   = ctrl;
      bus_a.in_alu_i    = alu;
      bus_a.in_mem_i    = mem;
      bus_a.in_rd_i     = rd;
      bus_a.out_ready_i = out_ready;
      bus_a.flush_i     = flush;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    $display("[TB] pipe_stage_reg directed run");
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);

    // Reset state
    #2;
    checkOutput("rst_out_valid", {31'b0, bus_a.out_valid_o}, 32'd0);
    checkOutput("rst_out_ctrl", {30'b0, bus_a.out_ctrl_o}, 32'd0);
    checkOutput("rst_occ", {30'b0, bus_a.occ_o}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, bus_a.in_ready_o}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    nextCycle();
    checkOutput("rst_alu", bus_a.out_alu_o, 32'd0);
    checkOutput("rst_mem", bus_a.out_mem_o, 32'd0);
    checkOutput("rst_rd", {27'b0, bus_a.out_rd_o}, 32'd0);

    // Streaming: 8 back-to-back entries, one per cycle, one cycle latency
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 1'b1, 2'b01, i, i * 16, i[4:0], 1'b1, 1'b0);
      nextCycle();
      checkOutput($sformatf("stream_valid_%0d", i), {31'b0, bus_a.out_valid_o}, 32'd1);
      checkOutput($sformatf("stream_alu_%0d", i), bus_a.out_alu_o, i);
      checkOutput($sformatf("stream_mem_%0d", i), bus_a.out_mem_o, i * 16);
      checkOutput($sformatf("stream_occ_%0d", i), {30'b0, bus_a.occ_o}, 32'd1);
    end
    checkOutput("stream_ctrl", {30'b0, bus_a.out_ctrl_o}, 32'd1);
    checkOutput("stream_rd", {27'b0, bus_a.out_rd_o}, 32'd8);

    // Bubble: invalid input with both control bits set
    applyStimulus(1'b0, 1'b0, 2'b11, 32'h99, 32'h99, 5'd9, 1'b1, 1'b0);
    nextCycle();
    checkOutput("bubble_valid", {31'b0, bus_a.out_valid_o}, 32'd0);
    checkOutput("bubble_ctrl", {30'b0, bus_a.out_ctrl_o}, 32'd0);
    checkOutput("bubble_occ", {30'b0, bus_a.occ_o}, 32'd0);

    // Back-pressure: A, B fill both slots, C is held upstream
    applyStimulus(1'b0, 1'b1, 2'b01, 32'hAAAA, 32'h1, 5'd1, 1'b0, 1'b0);
    nextCycle();
    checkOutput("bp_a_occ", {30'b0, bus_a.occ_o}, 32'd1);
    checkOutput("bp_a_in_ready", {31'b0, bus_a.in_ready_o}, 32'd1);
    applyStimulus(1'b0, 1'b1, 2'b01, 32'hBBBB, 32'h2, 5'd2, 1'b0, 1'b0);
    nextCycle();
    checkOutput("bp_b_occ", {30'b0, bus_a.occ_o}, 32'd2);
    checkOutput("bp_b_in_ready", {31'b0, bus_a.in_ready_o}, 32'd0);
    checkOutput("bp_b_head", bus_a.out_alu_o, 32'hAAAA);
    applyStimulus(1'b0, 1'b1, 2'b01, 32'hCCCC, 32'h3, 5'd3, 1'b0, 1'b0);
    nextCycle();
    checkOutput("bp_c_occ", {30'b0, bus_a.occ_o}, 32'd2);
    checkOutput("bp_c_head", bus_a.out_alu_o, 32'hAAAA);
    checkOutput("bp_c_head_rd", {27'b0, bus_a.out_rd_o}, 32'd1);
    applyStimulus(1'b0, 1'b1, 2'b01, 32'hCCCC, 32'h3, 5'd3, 1'b1, 1'b0);
    nextCycle();
    checkOutput("bp_rel_b", bus_a.out_alu_o, 32'hBBBB);
    checkOutput("bp_rel_b_occ", {30'b0, bus_a.occ_o}, 32'd1);
    checkOutput("bp_rel_b_ready", {31'b0, bus_a.in_ready_o}, 32'd1);
    nextCycle();
    checkOutput("bp_rel_c", bus_a.out_alu_o, 32'hCCCC);
    checkOutput("bp_rel_c_mem", bus_a.out_mem_o, 32'h3);
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    nextCycle();
    checkOutput("bp_drain_occ", {30'b0, bus_a.occ_o}, 32'd0);

    // Flush with both slots held and an incoming entry
    applyStimulus(1'b0, 1'b1, 2'b11, 32'hD, 32'h0, 5'd4, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 2'b11, 32'hE, 32'h0, 5'd5, 1'b0, 1'b0);
    nextCycle();
    checkOutput("fl_pre_occ", {30'b0, bus_a.occ_o}, 32'd2);
    applyStimulus(1'b0, 1'b1, 2'b11, 32'hF, 32'h0, 5'd6, 1'b0, 1'b1);
    nextCycle();
    checkOutput("fl_occ", {30'b0, bus_a.occ_o}, 32'd0);
    checkOutput("fl_valid", {31'b0, bus_a.out_valid_o}, 32'd0);
    checkOutput("fl_ctrl", {30'b0, bus_a.out_ctrl_o}, 32'd0);
    checkOutput("fl_in_ready", {31'b0, bus_a.in_ready_o}, 32'd1);
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    nextCycle();
    checkOutput("fl_after_valid", {31'b0, bus_a.out_valid_o}, 32'd0);

    // Flush while one entry held and the input actually fires
    applyStimulus(1'b0, 1'b1, 2'b01, 32'h6, 32'h0, 5'd7, 1'b0, 1'b0);
    nextCycle();
    checkOutput("fl1_pre_occ", {30'b0, bus_a.occ_o}, 32'd1);
    applyStimulus(1'b0, 1'b1, 2'b01, 32'h7, 32'h0, 5'd8, 1'b0, 1'b1);
    nextCycle();
    checkOutput("fl1_occ", {30'b0, bus_a.occ_o}, 32'd0);
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    nextCycle();
    checkOutput("fl1_after_valid", {31'b0, bus_a.out_valid_o}, 32'd0);

    // Reset mid-stream with two entries held
    applyStimulus(1'b0, 1'b1, 2'b01, 32'h11, 32'h12, 5'd3, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 2'b01, 32'h21, 32'h22, 5'd4, 1'b0, 1'b0);
    nextCycle();
    checkOutput("mrst_pre_occ", {30'b0, bus_a.occ_o}, 32'd2);
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mrst_valid", {31'b0, bus_a.out_valid_o}, 32'd0);
    checkOutput("mrst_ctrl", {30'b0, bus_a.out_ctrl_o}, 32'd0);
    checkOutput("mrst_occ", {30'b0, bus_a.occ_o}, 32'd0);
    checkOutput("mrst_in_ready", {31'b0, bus_a.in_ready_o}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    nextCycle();
    checkOutput("mrst_alu", bus_a.out_alu_o, 32'd0);
    checkOutput("mrst_mem", bus_a.out_mem_o, 32'd0);
    checkOutput("mrst_rd", {27'b0, bus_a.out_rd_o}, 32'd0);

    // Single-entry build: combinational ready and same-cycle replacement
    applyStimulus(1'b1, 1'b1, 2'b01, 32'h11, 32'h0, 5'd1, 1'b0, 1'b0);
    nextCycle();
    checkOutput("b_p_valid", {31'b0, bus_b.out_valid_o}, 32'd1);
    checkOutput("b_p_alu", bus_b.out_alu_o, 32'h11);
    checkOutput("b_p_occ", {30'b0, bus_b.occ_o}, 32'd1);
    checkOutput("b_p_in_ready", {31'b0, bus_b.in_ready_o}, 32'd0);
    applyStimulus(1'b1, 1'b1, 2'b01, 32'h22, 32'h0, 5'd2, 1'b1, 1'b0);
    #1;
    checkOutput("b_ready_same_cycle", {31'b0, bus_b.in_ready_o}, 32'd1);
    nextCycle();
    checkOutput("b_q_valid", {31'b0, bus_b.out_valid_o}, 32'd1);
    checkOutput("b_q_alu", bus_b.out_alu_o, 32'h22);
    checkOutput("b_q_occ", {30'b0, bus_b.occ_o}, 32'd1);
    applyStimulus(1'b1, 1'b1, 2'b01, 32'h33, 32'h0, 5'd3, 1'b0, 1'b0);
    #1;
    checkOutput("b_r_in_ready", {31'b0, bus_b.in_ready_o}, 32'd0);
    nextCycle();
    checkOutput("b_r_held", bus_b.out_alu_o, 32'h22);
    applyStimulus(1'b1, 1'b0, 2'b11, 32'h44, 32'h0, 5'd4, 1'b1, 1'b0);
    nextCycle();
    checkOutput("b_drain_valid", {31'b0, bus_b.out_valid_o}, 32'd0);
    checkOutput("b_bubble_ctrl", {30'b0, bus_b.out_ctrl_o}, 32'd0);
    checkOutput("b_drain_occ", {30'b0, bus_b.occ_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
